// File: rtl/decode_queue_pkg.sv
// ----------------------------------------------------------------------------
// decode_queue_pkg
// Shared definitions for the decode -> rename/dispatch queue: the field types
// of a decoded instruction, the queue entry payload and the default depth.
// ----------------------------------------------------------------------------
package decode_queue_pkg;

    localparam int unsigned DQ_DEPTH_DEFAULT = 8;

    typedef logic [3:0]  opt_t;
    typedef logic [3:0]  fun_t;
    typedef logic [1:0]  sel_t;
    typedef logic [31:0] pc_t;
    typedef logic [31:0] imm_t;
    typedef logic [4:0]  arc_reg_t;
    typedef logic [3:0]  exc_t;

    // One decoded instruction as carried through the queue
    typedef struct packed {
        opt_t           opt;
        fun_t           fun;
        sel_t     [1:0] sel;
        pc_t            pc;
        imm_t           imm;
        arc_reg_t [1:0] src;
        arc_reg_t       dst;
        exc_t           exc;
    } dq_entry_t;

endpackage

// File: rtl/decode_queue_lane_compact.sv
// ----------------------------------------------------------------------------
// lane_compact
// Packs sparse valid decode lanes into a dense prefix, preserving lane order.
// Pure combinational.
//   valid_i / entry_i : sparse incoming lanes
//   valid_o / entry_o : dense lanes, valid_o is a contiguous run from lane 0
//   count_o           : number of valid lanes (k)
// ----------------------------------------------------------------------------
module lane_compact
    import decode_queue_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 3
) (
    input  logic      [IN_WIDTH-1:0]            valid_i,
    input  dq_entry_t [IN_WIDTH-1:0]            entry_i,
    output logic      [IN_WIDTH-1:0]            valid_o,
    output dq_entry_t [IN_WIDTH-1:0]            entry_o,
    output logic      [$clog2(IN_WIDTH+1)-1:0]  count_o
);

    localparam int unsigned KW = $clog2(IN_WIDTH + 1);

    // Each valid lane lands at the position equal to the number of valid lanes below it
    always_comb begin
        logic [KW-1:0] pos;
        valid_o = '0;
        entry_o = '0;
        pos     = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (valid_i[i]) begin
                for (int p = 0; p < IN_WIDTH; p++) begin
                    if (KW'(p) == pos) begin
                        entry_o[p] = entry_i[i];
                        valid_o[p] = 1'b1;
                    end
                end
                pos = pos + KW'(1);
            end
        end
        count_o = pos;
    end

endmodule

// File: rtl/decode_queue.sv
// ----------------------------------------------------------------------------
// decode_queue
// In-order queue between decode and rename/dispatch. Accepts up to IN_WIDTH
// sparse decode lanes per cycle (compacted), presents up to OUT_WIDTH oldest
// entries per cycle, and removes the leading run of accepted lanes.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   flush             : drop all contents and this cycle's enqueue/dequeue
//   avail[i]          : at least i+1 free entries (start-of-cycle state)
//   in_valid/in_entry : decode lanes, may be sparse
//   out_valid/out_entry/out_ready : dispatch lanes, lane 0 oldest
//   overflow          : sticky, set when a valid lane had to be dropped
// Optional feature macro: DECODE_QUEUE_BYPASS_EN -- when the queue is empty
// and not flushing, compacted incoming lanes are presented in the same cycle.
// ----------------------------------------------------------------------------
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned OUT_WIDTH = 3,
    parameter int unsigned DEPTH     = DQ_DEPTH_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    output logic      [IN_WIDTH-1:0]    avail,
    input  logic      [IN_WIDTH-1:0]    in_valid,
    input  dq_entry_t [IN_WIDTH-1:0]    in_entry,
    output logic      [OUT_WIDTH-1:0]   out_valid,
    output dq_entry_t [OUT_WIDTH-1:0]   out_entry,
    input  logic      [OUT_WIDTH-1:0]   out_ready,
    output logic                        overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned KW = $clog2(IN_WIDTH + 1);

    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    dq_entry_t      mem_q [DEPTH];

    logic      [IN_WIDTH-1:0] dense_valid;
    dq_entry_t [IN_WIDTH-1:0] dense_entry;
    logic      [KW-1:0]       k;

    logic [CW-1:0]  free;
    logic [CW-1:0]  accepted;
    logic [CW-1:0]  deq_cnt;
    logic [CW-1:0]  skip;
    logic           byp_active;

    logic [IN_WIDTH-1:0] wr_en;
    logic [PW-1:0]       wr_idx [IN_WIDTH];

    lane_compact #(
        .IN_WIDTH (IN_WIDTH)
    ) u_compact (
        .valid_i (in_valid),
        .entry_i (in_entry),
        .valid_o (dense_valid),
        .entry_o (dense_entry),
        .count_o (k)
    );

`ifdef DECODE_QUEUE_BYPASS_EN
    assign byp_active = (count_q == '0) && !flush;
`else
    assign byp_active = 1'b0;
`endif

    // Free slots and per-lane availability from start-of-cycle occupancy
    always_comb begin
        free  = CW'(DEPTH) - count_q;
        avail = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            avail[i] = (free >= CW'(i + 1));
        end
    end

    // Presentation: stored entries from head, or the compacted inputs when bypassing
    always_comb begin
        out_valid = '0;
        out_entry = '0;
        if (byp_active) begin
            for (int j = 0; j < OUT_WIDTH; j++) begin
                for (int p = 0; p < IN_WIDTH; p++) begin
                    if (p == j) begin
                        out_valid[j] = dense_valid[p];
                        out_entry[j] = dense_entry[p];
                    end
                end
            end
        end else begin
            for (int j = 0; j < OUT_WIDTH; j++) begin
                out_valid[j] = (count_q > CW'(j));
                out_entry[j] = mem_q[head_q + PW'(j)];
            end
        end
    end

    // Dequeue count: only the leading run of valid & ready lanes leaves
    always_comb begin
        logic run;
        run     = 1'b1;
        deq_cnt = '0;
        for (int j = 0; j < OUT_WIDTH; j++) begin
            if (run && out_valid[j] && out_ready[j]) begin
                deq_cnt = deq_cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Enqueue: accept the lowest 'free' dense lanes; bypassed lanes taken this cycle are skipped
    always_comb begin
        accepted = (CW'(k) > free) ? free : CW'(k);
        skip     = byp_active ? deq_cnt : '0;
        for (int p = 0; p < IN_WIDTH; p++) begin
            wr_en[p]  = !flush && dense_valid[p] && (CW'(p) >= skip) && (CW'(p) < accepted);
            wr_idx[p] = tail_q + PW'(p) - PW'(skip);
        end
    end

    // Next-state pointers, occupancy and sticky overflow
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // In bypass, the taken lanes were never stored, so head does not move for them
            head_d     = head_q + PW'(deq_cnt - skip);
            tail_d     = tail_q + PW'(accepted - skip);
            count_d    = count_q + accepted - deq_cnt;
            overflow_d = overflow_q | (CW'(k) > free);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clock) begin
        for (int p = 0; p < IN_WIDTH; p++) begin
            if (wr_en[p]) begin
                mem_q[wr_idx[p]] <= dense_entry[p];
            end
        end
    end

    assign overflow = overflow_q;

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised in-order queue between the decoder and rename/dispatch. It generalises the fixed three-lane decode hand-off: a configurable number of enqueue and dequeue lanes, DEPTH entries of buffering, and compaction of sparse valid lanes. Per-lane `avail` flow control goes back to fetch/decode, and a flush port discards all buffered work on redirect.

## Interface
- `IN_WIDTH`, 3: decode lanes enqueued per cycle.
- `OUT_WIDTH`, 3: dispatch lanes presented per cycle.
- `DEPTH`, 8: entries. Must be a power of two and ≥ max(IN_WIDTH, OUT_WIDTH).
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `flush` input 1: discard all contents and same-cycle enqueues.
- `avail` output IN_WIDTH: `avail[i]` = at least i+1 free entries.
- `in_valid` input IN_WIDTH: lane carries a decoded instruction. Lanes may be sparse.
- `in_entry` input IN_WIDTH × `dq_entry_t`: opt, fun, sel[2], pc, imm, src[2], dst, exc.
- `out_valid` output OUT_WIDTH: `out_valid[j]` = entry head+j present.
- `out_entry` output OUT_WIDTH × `dq_entry_t`: entries in program order, lane 0 oldest.
- `out_ready` input OUT_WIDTH: consumer accepts lane j.
- `overflow` output 1: sticky error, set when an enqueue is dropped.

## Operation
- **State:** `head`, `tail` (log2 DEPTH bits, wrap modulo DEPTH), `count` (log2(DEPTH+1) bits), entry array.
- **Enqueue:**
  - Let k = popcount(in_valid). Valid lanes are written to tail, tail+1, … in ascending lane order, skipping holes.
  - tail advances by k. Pointer addition is modulo DEPTH.
- **Enqueue legality:** the producer must satisfy k ≤ free, where free = DEPTH − count at start of cycle.
  - If k > free, the lowest `free` valid lanes are accepted, the rest are dropped, and `overflow` is set until reset.
- **Dequeue:**
  - d = length of the leading run of lanes j with `out_valid[j] & out_ready[j]`.
  - A ready lane after a non-ready lane is ignored; no out-of-order removal.
  - head advances by d.
- **Count update:** count_next = count + accepted − d.
- **Flush:**
  - head, tail, count ← 0 on the next edge.
  - Same-cycle enqueue and dequeue are both discarded. `out_valid` is still driven from current state during that cycle.
- **Reset values:** head = tail = count = 0, `avail` all 1, `out_valid` all 0, `overflow` = 0. Entry array contents are don't-care.

## Timing
- `avail` and `out_valid`/`out_entry` are functions of registered state only; there is no combinational path from `in_*` (see Configuration for the exception).
- Enqueue-to-visible latency is 1 cycle: written at edge N, `out_valid` at N+1.
- `avail` reflects start-of-cycle count and excludes same-cycle dequeue. Freed slots appear one cycle later.
- **Full (count = DEPTH):** `avail` = 0. Dequeue still proceeds.
- **Empty:** `out_valid` = 0. Enqueue proceeds.
- **Wrap-around:** a multi-lane write or read crossing index DEPTH−1 continues at 0 in the same cycle.
- **Reset mid-operation:** asynchronous clear of all state; the next cycle behaves as empty.

## Configuration
- **`DECODE_QUEUE_BYPASS_EN` defined:**
  - When count = 0 and `flush` = 0, incoming valid lanes (compacted) drive `out_valid`/`out_entry` combinationally in the same cycle.
  - Lanes taken by the consumer that cycle are not written. Remaining lanes are written from tail.
  - This adds an `in_*` → `out_*` combinational path.
- **Undefined:** no bypass; minimum latency 1 cycle as above.

## Structure
- Shared package (defs): `dq_entry_t` packed struct built from the existing opt_t, fun_t, sel_t, pc_t, imm_t, arc_reg_t, exc_t types; `DQ_DEPTH_DEFAULT`.
- One sub-module, `lane_compact`: converts IN_WIDTH sparse valid lanes into a dense prefix with count k. It is pure combinational and reused for bypass.

## Test plan
- **Reset:** assert `reset` mid-stream with count = 5 → immediately `out_valid` = 0, `avail` = 3'b111, `overflow` = 0.
- **Sparse enqueue:** in_valid = 3'b101 with pcs 0x100 and 0x108 into an empty queue → next cycle `out_valid` = 3'b011, lane0 pc 0x100, lane1 pc 0x108, count 2.
- **Partial dequeue:** count 3, out_ready = 3'b101 → only lane 0 removed, head+1, count 2.
- **Full and overflow:**
  - Fill to 8 → `avail` = 0.
  - Enqueue 1 lane → dropped, `overflow` = 1.
  - Dequeue 2 → `avail` = 3'b011 next cycle.
- **Wrap:** head = tail = 6, enqueue 3 → entries at 6, 7, 0; next cycle dequeue 3 returns them in order, head = 1.
- **Flush priority:** count 4, flush with in_valid = 3'b111 and out_ready all 1 → next cycle count 0, `out_valid` = 0. With `DECODE_QUEUE_BYPASS_EN`, the empty queue plus in_valid = 3'b001 shows `out_valid[0]` in the same cycle.
